// File: rtl/vga_pkg.sv
// Shared types and raster-boundary helpers for the VGA timing generator.
// Pure declarations: no latency, no flow control.
package vga_pkg;

    localparam int WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_first(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_last(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the timing generator; frame_cnt exists only with
// VGA_TIMING_FRAME_CNT_EN. No handshake: outputs advance on the ce tick.
interface vga_timing_if import vga_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             ce;
    logic             en;
    logic [WIDTH-1:0] hcount;
    logic [WIDTH-1:0] vcount;
    logic [WIDTH-1:0] fetch_x;
    logic [WIDTH-1:0] fetch_y;
    logic             hsync;
    logic             vsync;
    logic             hblank;
    logic             vblank;
    logic             de;
    logic             sol;
    logic             sof;
    logic             fetch_valid;
    logic             running;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        input  ce, en,
        output hcount, vcount, fetch_x, fetch_y, hsync, vsync, hblank, vblank,
               de, sol, sof, fetch_valid, running, frame_cnt
    );
    modport slave (
        output ce, en,
        input  hcount, vcount, fetch_x, fetch_y, hsync, vsync, hblank, vblank,
               de, sol, sof, fetch_valid, running, frame_cnt
    );
`else
    modport master (
        input  ce, en,
        output hcount, vcount, fetch_x, fetch_y, hsync, vsync, hblank, vblank,
               de, sol, sof, fetch_valid, running
    );
    modport slave (
        output ce, en,
        input  hcount, vcount, fetch_x, fetch_y, hsync, vsync, hblank, vblank,
               de, sol, sof, fetch_valid, running
    );
`endif
endinterface

// File: rtl/vga_timing_gen_raster_counter.sv
// Two-axis raster position counter with wrap/carry and a load to its start offset.
// Registered x/y; nx/ny expose the value taken at the next edge. Moves only on adv/load.
module raster_counter import vga_pkg::*; #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int X0      = 0,
    parameter int Y0      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             load,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] nx,
    output logic [WIDTH-1:0] ny
);
    localparam logic [WIDTH-1:0] X_LAST = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] X_INIT = WIDTH'(X0);
    localparam logic [WIDTH-1:0] Y_INIT = WIDTH'(Y0);

    always_comb begin
        nx = x;
        ny = y;
        if (load) begin
            nx = X_INIT;
            ny = Y_INIT;
        end else if (adv) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = (y == Y_LAST) ? '0 : y + WIDTH'(1);
            end else begin
                nx = x + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= X_INIT;
            y <= Y_INIT;
        end else begin
            x <= nx;
            y <= ny;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; frame_cnt added with VGA_TIMING_FRAME_CNT_EN.
// Outputs registered, 1 clk after a ce tick; nothing moves while ce is low.
module vga_timing_gen import vga_pkg::*; #(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PREFETCH = 2
) (
    input logic          clk,
    input logic          rst,
    vga_timing_if.master bus
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [WIDTH-1:0] H_LAST = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] H_ACT  = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] V_ACT  = WIDTH'(V_ACTIVE);
    localparam logic [WIDTH-1:0] HS_LO  = WIDTH'(sync_first(H_ACTIVE, H_FP));
    localparam logic [WIDTH-1:0] HS_HI  = WIDTH'(sync_last(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [WIDTH-1:0] VS_LO  = WIDTH'(sync_first(V_ACTIVE, V_FP));
    localparam logic [WIDTH-1:0] VS_HI  = WIDTH'(sync_last(V_ACTIVE, V_FP, V_SYNC));
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    state_t           state, state_nxt;
    logic             live, adv, load, wrap;
    logic [WIDTH-1:0] h_cur, v_cur, h_nxt, v_nxt;
    logic [WIDTH-1:0] fx_cur, fy_cur, fx_nxt, fy_nxt;
    logic             hsync_d, vsync_d, hblank_d, vblank_d, sol_d, sof_d, fv_d;

    assign wrap = (h_cur == H_LAST) && (v_cur == V_LAST);

    always_comb begin
        state_nxt = state;
        if (bus.ce) begin
            case (state)
                IDLE:    if (bus.en) state_nxt = RUN;
                RUN:     if (!bus.en) state_nxt = DRAIN;
                DRAIN:   if (bus.en) state_nxt = RUN;
                         else if (wrap) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Leaving IDLE shows (0,0) without advancing; entering IDLE parks both counters.
    assign live = (state_nxt != IDLE);
    assign load = bus.ce && !live;
    assign adv  = bus.ce && live && (state != IDLE);

    raster_counter #(.WIDTH(WIDTH), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
                     .X0(0), .Y0(0)) u_disp (
        .clk(clk), .rst(rst), .adv(adv), .load(load),
        .x(h_cur), .y(v_cur), .nx(h_nxt), .ny(v_nxt)
    );

    raster_counter #(.WIDTH(WIDTH), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
                     .X0(PREFETCH % H_TOTAL), .Y0((PREFETCH / H_TOTAL) % V_TOTAL)) u_fetch (
        .clk(clk), .rst(rst), .adv(adv), .load(load),
        .x(fx_cur), .y(fy_cur), .nx(fx_nxt), .ny(fy_nxt)
    );

    // Decode the position the counters take at this edge so flags stay aligned with it.
    always_comb begin
        hsync_d  = ~HS_ON;
        vsync_d  = ~VS_ON;
        hblank_d = 1'b1;
        vblank_d = 1'b1;
        sol_d    = 1'b0;
        sof_d    = 1'b0;
        fv_d     = 1'b0;
        if (live) begin
            hsync_d  = (h_nxt >= HS_LO && h_nxt <= HS_HI) ? HS_ON : ~HS_ON;
            vsync_d  = (v_nxt >= VS_LO && v_nxt <= VS_HI) ? VS_ON : ~VS_ON;
            hblank_d = (h_nxt >= H_ACT);
            vblank_d = (v_nxt >= V_ACT);
            sol_d    = (h_nxt == '0);
            sof_d    = (h_nxt == '0) && (v_nxt == '0);
            fv_d     = (fx_nxt < H_ACT) && (fy_nxt < V_ACT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bus.hsync       <= ~HS_ON;
            bus.vsync       <= ~VS_ON;
            bus.hblank      <= 1'b1;
            bus.vblank      <= 1'b1;
            bus.de          <= 1'b0;
            bus.sol         <= 1'b0;
            bus.sof         <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.running     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.ce) begin
                bus.hsync       <= hsync_d;
                bus.vsync       <= vsync_d;
                bus.hblank      <= hblank_d;
                bus.vblank      <= vblank_d;
                bus.de          <= !hblank_d && !vblank_d;
                bus.sol         <= sol_d;
                bus.sof         <= sof_d;
                bus.fetch_valid <= fv_d;
                bus.running     <= live;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bus.frame_cnt <= '0;
        else if (bus.ce && sof_d)
            bus.frame_cnt <= bus.frame_cnt + 16'd1;
    end
`endif

    assign bus.hcount  = h_cur;
    assign bus.vcount  = v_cur;
    assign bus.fetch_x = fx_cur;
    assign bus.fetch_y = fy_cur;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1, PREFETCH 2),
// with a second instance at active-high sync polarity driven identically.
module tb_vga_timing_gen;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_if #(.WIDTH(W)) bus ();
    vga_timing_if #(.WIDTH(W)) bus_p ();

    vga_timing_gen #(.WIDTH(W), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .PREFETCH(2))
        dut (.clk(clk), .rst(rst), .bus(bus.master));

    vga_timing_gen #(.WIDTH(W), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1), .VS_POL(1), .PREFETCH(2))
        dut_p (.clk(clk), .rst(rst), .bus(bus_p.master));

    int checks = 0;
    int errors = 0;
    int eh = 0, ev = 0, frames = 0;
    int tick_no = 0, last_sof = 0, sof_gap = 0;
    int de_cnt = 0, sof_cnt = 0, hs_lo = 0, vs_lo = 0;
    int sol_clks = 0, sof_clks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic e);
        bus.ce = c;  bus.en = e;
        bus_p.ce = c; bus_p.en = e;
    endtask

    function automatic logic [63:0] obs_vec();
        return {5'd0, bus.hcount, bus.vcount, bus.fetch_x, bus.fetch_y,
                bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.de,
                bus.sol, bus.sof, bus.fetch_valid, bus.running,
                bus_p.hsync, bus_p.vsync};
    endfunction

    function automatic logic [63:0] exp_run(input int h, input int v);
        int f;
        logic hs_on, vs_on, hb, vb;
        f = (v * 16 + h + 2) % 128;
        hs_on = (h >= 10 && h <= 12);
        vs_on = (v >= 5 && v <= 6);
        hb = (h >= 8);
        vb = (v >= 4);
        return {5'd0, 12'(h), 12'(v), 12'(f % 16), 12'(f / 16),
                ~hs_on, ~vs_on, hb, vb, ~hb & ~vb,
                (h == 0), (h == 0 && v == 0), ((f % 16) < 8 && (f / 16) < 4), 1'b1,
                hs_on, vs_on};
    endfunction

    function automatic logic [63:0] exp_idle();
        return {5'd0, 12'd0, 12'd0, 12'd2, 12'd0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic adv_model();
        eh++;
        if (eh == 16) begin
            eh = 0;
            ev = (ev == 7) ? 0 : ev + 1;
        end
        if (eh == 0 && ev == 0) frames++;
    endtask

    task automatic check_cnt(input string tag);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(frames));
`else
        chk({tag, "_running_p"}, 64'(bus_p.running), 64'(bus.running));
`endif
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            adv_model();
            @(posedge clk); #1;
            tick_no++;
            chk(tag, obs_vec(), exp_run(eh, ev));
            if (bus.de) de_cnt++;
            if (!bus.hsync) hs_lo++;
            if (!bus.vsync) vs_lo++;
            if (bus.sof) begin
                sof_cnt++;
                sof_gap = tick_no - last_sof;
                last_sof = tick_no;
            end
        end
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        for (int i = 0; i < 300 && !(eh == h && ev == v); i++) run(1, tag);
    endtask

    task automatic run_slow(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            adv_model();
            drive(1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                drive(1'b0, 1'b1);
                chk(tag, obs_vec(), exp_run(eh, ev));
                if (bus.sol) sol_clks++;
                if (bus.sof) sof_clks++;
            end
        end
        drive(1'b1, 1'b1);
    endtask

    initial begin
        drive(1'b0, 1'b0);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_idle", obs_vec(), exp_idle());
        check_cnt("reset");

        @(negedge clk) rst = 1'b1;
        drive(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_en_low", obs_vec(), exp_idle());

        // First tick after en rises must already show (0,0) with sof and de.
        drive(1'b1, 1'b1);
        @(posedge clk); #1;
        eh = 0; ev = 0; frames = 1;
        chk("start_00", obs_vec(), exp_run(0, 0));
        chk("start_sof", 64'(bus.sof), 64'd1);
        check_cnt("start");
        de_cnt = 1; sof_cnt = 1; hs_lo = 0; vs_lo = 0; tick_no = 0; last_sof = 0;
        run(255, "full_rate");
        chk("de_per_2frames", 64'(de_cnt), 64'd64);
        chk("sof_per_2frames", 64'(sof_cnt), 64'd2);
        chk("sof_gap", 64'(sof_gap), 64'd128);
        chk("hsync_low_cnt", 64'(hs_lo), 64'd48);
        chk("vsync_low_cnt", 64'(vs_lo), 64'd64);
        check_cnt("two_frames");

        run_slow(32, "ce_1of3");
        chk("sol_clks", 64'(sol_clks), 64'd6);
        chk("sof_clks", 64'(sof_clks), 64'd3);
        check_cnt("three_frames");

        run_to(3, 2, "to_3_2");
        drive(1'b1, 1'b0);
        run_to(15, 7, "drain");
        chk("drain_running", 64'(bus.running), 64'd1);
        @(posedge clk); #1;
        eh = 0; ev = 0;
        chk("drain_idle", obs_vec(), exp_idle());
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", obs_vec(), exp_idle());
        check_cnt("idle_hold");

        drive(1'b1, 1'b1);
        @(posedge clk); #1;
        frames++;
        chk("restart_00", obs_vec(), exp_run(0, 0));

        run_to(3, 2, "to_3_2b");
        drive(1'b1, 1'b0);
        run_to(10, 6, "drain_b");
        drive(1'b1, 1'b1);
        run_to(15, 7, "rerun");
        run(1, "no_stop");
        chk("no_stop_running", 64'(bus.running), 64'd1);
        chk("no_stop_sof", 64'(bus.sof), 64'd1);

        // Reset mid-cycle, away from any clock edge.
        run_to(5, 3, "to_5_3");
        #2 rst = 1'b0;
        #1;
        frames = 0;
        chk("async_reset", obs_vec(), exp_idle());
        check_cnt("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        eh = 0; ev = 0; frames = 1;
        chk("reset_restart", obs_vec(), exp_run(0, 0));
        chk("reset_restart_sof", 64'(bus.sof), 64'd1);

        run_to(13, 7, "to_13_7");
        chk("fetch_pre", 64'(bus.fetch_valid), 64'd0);
        run(1, "fetch_rise_vec");
        chk("fetch_rise", 64'(bus.fetch_valid), 64'd1);
        chk("fetch_xy_00", 64'({bus.fetch_x, bus.fetch_y}), 64'd0);
        check_cnt("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
